// File: rtl/console_tx_pkg.sv
// Shared constants for the console transmitter: FSM encodings and byte width.
// The PARITY state only exists when CONSOLE_TX_PARITY_EN is defined.
package console_tx_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef CONSOLE_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } tx_state_e;

   function automatic logic even_parity(input logic [BYTE_W-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO for the console transmitter: power-of-two depth, wrapping pointers,
// a push is accepted when full only if a pop happens in the same cycle.
module console_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     push_ok,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
         else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/console_tx.sv
// Console UART transmitter: core stores bytes into a FIFO, an FSM serialises them 8N1.
// Define CONSOLE_TX_PARITY_EN to insert an even-parity bit (8E1).
//
// state  | meaning
// IDLE   | line high; pops the next byte when the FIFO is non-empty
// START  | start bit (tx=0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the byte (CONSOLE_TX_PARITY_EN only)
// STOP   | stop bit (tx=1), then back to IDLE
module console_tx
   import console_tx_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [XLEN-1:0]               console_wdata,
   input  logic                          console_we,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_e          state;
   logic [BW-1:0]      baud_cnt;
   logic [2:0]         bit_cnt;
   logic [BYTE_W-1:0]  shift;
   logic [BYTE_W-1:0]  fifo_rdata;
   logic               fifo_empty;
   logic               fifo_pop;
   logic               push_ok;
   logic               unused_fifo_full;
`ifdef CONSOLE_TX_PARITY_EN
   logic               parity_q;
`endif

   if (XLEN > BYTE_W) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^console_wdata[XLEN-1:BYTE_W];
   end

   assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
   assign busy     = (state != ST_IDLE) || (fifo_count != '0);

   console_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (console_we),
      .wdata   (console_wdata[BYTE_W-1:0]),
      .pop     (fifo_pop),
      .rdata   (fifo_rdata),
      .push_ok (push_ok),
      .full    (unused_fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overflow <= 1'b0;
      else if (console_we && !push_ok) overflow <= 1'b1;
   end

   // tx is driven from the same register bank as state so it never glitches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
`ifdef CONSOLE_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (!fifo_empty) begin
                  shift    <= fifo_rdata;
`ifdef CONSOLE_TX_PARITY_EN
                  parity_q <= even_parity(fifo_rdata);
`endif
                  baud_cnt <= BAUD_LAST;
                  bit_cnt  <= '0;
                  tx       <= 1'b0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_LAST;
                  tx       <= shift[0];
                  shift    <= shift >> 1;
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            ST_DATA: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_LAST;
                  if (bit_cnt == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
                     tx    <= parity_q;
                     state <= ST_PARITY;
`else
                     tx    <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
`ifdef CONSOLE_TX_PARITY_EN
            ST_PARITY: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_LAST;
                  tx       <= 1'b1;
                  state    <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
`endif
            ST_STOP: begin
               tx <= 1'b1;
               if (baud_cnt == '0) state <= ST_IDLE;
               else                baud_cnt <= baud_cnt - BW'(1);
            end
            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_console_tx.sv
// Scoreboard bench for console_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4): accepted bytes are
// queued on write; a serial monitor decodes tx frames and checks them against the queue.
module tb_console_tx;

   localparam int C     = 4;
   localparam int DEPTH = 4;
`ifdef CONSOLE_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] console_wdata = '0;
   logic        console_we = 1'b0;
   logic        tx;
   logic        busy;
   logic        overflow;
   logic [2:0]  fifo_count;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  sb[$];

   always #5 clk = ~clk;

   console_tx #(
      .XLEN         (32),
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .console_wdata (console_wdata),
      .console_we    (console_we),
      .tx            (tx),
      .busy          (busy),
      .overflow      (overflow),
      .fifo_count    (fifo_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Called at a negedge; holds the write strobe across the next rising edge.
   task automatic put(input logic [31:0] d, input bit accept);
      console_we    = 1'b1;
      console_wdata = d;
      if (accept) sb.push_back(d[7:0]);
      @(negedge clk);
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef CONSOLE_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Cycle-exact frame check, starting at the negedge right after the write edge.
   task automatic frame_exact(input logic [7:0] b, input string name);
      int bad = -1;
      check({name, "_count_after_write"}, fifo_count, 1);
      check({name, "_tx_before_start"}, tx, 1);
      for (int i = 0; i < NBITS * C; i++) begin
         @(negedge clk);
         if (bad < 0 && tx !== frame_bit(b, i / C)) bad = i;
      end
      check({name, "_first_bad_cycle"}, bad, 32'hFFFF_FFFF);
      @(negedge clk);
      check({name, "_busy_after_stop"}, busy, 0);
      check({name, "_tx_after_stop"}, tx, 1);
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n = 0;
      while ((busy !== 1'b0 || sb.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, (busy === 1'b0 && sb.size() == 0), 1);
   endtask

   // Serial monitor: samples each bit mid-way; a reset during the frame discards it.
   initial begin : monitor
      logic [7:0] b;
      logic [7:0] exp_b;
      logic       s0;
      logic       stp;
      logic       par;
      bit         ab;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && tx === 1'b0) begin
            ab  = 1'b0;
            par = 1'b0;
            for (int k = 0; k < C / 2; k++) begin
               @(negedge clk);
               if (reset !== 1'b1) ab = 1'b1;
            end
            s0 = tx;
            for (int i = 0; i < 8; i++) begin
               for (int k = 0; k < C; k++) begin
                  @(negedge clk);
                  if (reset !== 1'b1) ab = 1'b1;
               end
               b[i] = tx;
            end
`ifdef CONSOLE_TX_PARITY_EN
            for (int k = 0; k < C; k++) begin
               @(negedge clk);
               if (reset !== 1'b1) ab = 1'b1;
            end
            par = tx;
`endif
            for (int k = 0; k < C; k++) begin
               @(negedge clk);
               if (reset !== 1'b1) ab = 1'b1;
            end
            stp = tx;
            if (!ab) begin
               check("mon_start_bit", s0, 0);
               check("mon_frame_expected", (sb.size() != 0), 1);
               if (sb.size() != 0) begin
                  exp_b = sb.pop_front();
                  check("mon_data", b, exp_b);
`ifdef CONSOLE_TX_PARITY_EN
                  check("mon_parity", par, ^exp_b);
`endif
                  check("mon_stop_bit", stp, 1);
               end
            end
         end
      end
   end

   initial begin : stim
      int bad;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_overflow", overflow, 0);

      // first edge after release accepts the write; exact 0x41 frame
      reset = 1'b1;
      put(32'h41, 1);
      console_we = 1'b0;
      frame_exact(8'h41, "f41");

      // only the low byte is sent
      @(negedge clk);
      put(32'h1234_5655, 1);
      console_we = 1'b0;
      wait_idle(200, "wide_word");

      @(negedge clk);
      put(32'h07, 1);
      console_we = 1'b0;
      frame_exact(8'h07, "f07");

      // six back-to-back writes into a depth-4 FIFO: the sixth is dropped
      @(negedge clk);
      for (int i = 0; i < 5; i++) put(32'h30 + i, 1);
      check("burst_count_full", fifo_count, 4);
      check("burst_overflow_before", overflow, 0);
      put(32'h35, 0);
      console_we = 1'b0;
      check("burst_overflow_after", overflow, 1);
      check("burst_count_after_drop", fifo_count, 4);
      wait_idle(1000, "burst");
      check("overflow_sticky", overflow, 1);

      // push while full, in the same cycle as the IDLE pop
      reset = 1'b0;
      @(negedge clk);
      check("rst2_overflow", overflow, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) put(32'hA0 + i, 1);
      console_we = 1'b0;
      check("full_pop_count_pre", fifo_count, 4);
      repeat (NBITS * C + 1 - 4) @(negedge clk);
      check("full_pop_idle_tx", tx, 1);
      check("full_pop_count_idle", fifo_count, 4);
      put(32'h00, 1);
      console_we = 1'b0;
      check("full_pop_count_same", fifo_count, 4);
      check("full_pop_overflow", overflow, 0);
      check("full_pop_next_start", tx, 0);
      wait_idle(2000, "full_pop");

      // reset in the middle of data bit 3 aborts at once
      @(negedge clk);
      put(32'h52, 1);
      put(32'h3C, 1);
      console_we = 1'b0;
      repeat (17) @(negedge clk);
      check("abort_mid_frame_tx", tx, 0);
      sb.delete();
      #1 reset = 1'b0;
      #1;
      check("abort_tx", tx, 1);
      check("abort_busy", busy, 0);
      check("abort_count", fifo_count, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("abort_stays_idle", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
